// File: rtl/pipelined_cl_adder.sv
// Pipelined carry-lookahead adder: one C_WIDTH/C_STAGES-bit segment per stage, valid/ready on both sides.
// Define PIPE_ADDER_SUB_EN to add the sub port (y = a + ~b + 1 when sub=1).
module pipelined_cl_adder #(
  parameter int unsigned C_WIDTH  = 32,
  parameter int unsigned C_STAGES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
`ifdef PIPE_ADDER_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH:0]   y
);

  localparam int unsigned SEG = C_WIDTH / C_STAGES;

  // Full 4-bit groups use sum-of-products lookahead; a trailing partial group ripples.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] z,
                                           input logic           ci);
    logic [SEG-1:0] g, p, s;
    logic [4:0]     cv;
    logic           c, gen, prop;
    g  = x & z;
    p  = x ^ z;
    s  = '0;
    cv = '0;
    c  = ci;
    for (int unsigned base = 0; base < SEG; base += 4) begin
      if (base + 4 <= SEG) begin
        for (int unsigned j = 0; j <= 4; j++) begin
          gen  = 1'b0;
          prop = 1'b1;
          for (int unsigned m = 0; m < j; m++) begin
            gen  = gen | (g[base+j-1-m] & prop);
            prop = prop & p[base+j-1-m];
          end
          cv[j] = gen | (prop & c);
        end
        for (int unsigned j = 0; j < 4; j++) s[base+j] = p[base+j] ^ cv[j];
        c = cv[4];
      end else begin
        for (int unsigned j = base; j < SEG; j++) begin
          s[j] = p[j] ^ c;
          c    = g[j] | (p[j] & c);
        end
      end
    end
    return {c, s};
  endfunction

  logic [C_STAGES-1:0] v_vec;
  logic [C_STAGES-1:0] adv;
  logic [C_WIDTH-1:0]  b_in;
  logic                cin0;

`ifdef PIPE_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign cin0 = sub;
`else
  assign b_in = b;
  assign cin0 = 1'b0;
`endif

  // A stage may advance if it is empty or everything downstream of it advances.
  always_comb begin
    logic acc;
    acc = out_ready;
    adv = '0;
    for (int unsigned i = 0; i < C_STAGES; i++) begin
      acc                 = acc | ~v_vec[C_STAGES-1-i];
      adv[C_STAGES-1-i]   = acc;
    end
  end

  for (genvar k = 0; k < C_STAGES; k++) begin : g_stage
    localparam int unsigned RW = (k + 1) * SEG;
    logic          v_q, v_d, c_q;
    logic [RW-1:0] r_q, r_d;
    logic [SEG:0]  sum;

    if (k == 0) begin : g_in
      assign sum = seg_add(a[SEG-1:0], b_in[SEG-1:0], cin0);
      assign r_d = sum[SEG-1:0];
      assign v_d = in_valid;
    end else begin : g_in
      assign sum = seg_add(g_stage[k-1].g_ops.a_q[SEG-1:0],
                           g_stage[k-1].g_ops.b_q[SEG-1:0],
                           g_stage[k-1].c_q);
      assign r_d = {sum[SEG-1:0], g_stage[k-1].r_q};
      assign v_d = g_stage[k-1].v_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv[k]) begin
        v_q <= v_d;
        c_q <= sum[SEG];
        r_q <= r_d;
      end
    end

    // Only the not-yet-added upper operand segments travel with the stage.
    if (k < C_STAGES - 1) begin : g_ops
      localparam int unsigned UW = C_WIDTH - RW;
      logic [UW-1:0] a_q, b_q, a_d, b_d;

      if (k == 0) begin : g_src
        assign a_d = a[C_WIDTH-1:SEG];
        assign b_d = b_in[C_WIDTH-1:SEG];
      end else begin : g_src
        assign a_d = g_stage[k-1].g_ops.a_q[UW+SEG-1:SEG];
        assign b_d = g_stage[k-1].g_ops.b_q[UW+SEG-1:SEG];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k]) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    assign v_vec[k] = v_q;
  end

  assign in_ready  = adv[0];
  assign out_valid = v_vec[C_STAGES-1];
  assign y         = {g_stage[C_STAGES-1].c_q, g_stage[C_STAGES-1].r_q};

endmodule
